// File: rtl/cache_2way_wb_if.sv
// cache_2way_wb_if: CPU load/store port plus word-addressed memory port
// slave = cache side, master = CPU/memory side
interface cache_2way_wb_if #(
  parameter int MEM_WIDTH = 32,
  parameter int MEM_DEPTH = 2**16
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int BYTE_W     = $clog2(MEM_WIDTH / 8);
  localparam int FULL_WIDTH = ADDR_WIDTH + BYTE_W;

  logic [FULL_WIDTH-1:0] address;
  logic [MEM_WIDTH-1:0]  din;
  logic                  rden;
  logic                  wren;
  logic                  ready;
  logic                  done;
  logic                  hit_miss;
  logic [MEM_WIDTH-1:0]  q;
  logic [MEM_WIDTH-1:0]  mdout;
  logic                  mrden;
  logic                  mwren;
  logic [ADDR_WIDTH-1:0] maddress;
  logic [MEM_WIDTH-1:0]  mq;
  logic                  mready;

  modport slave (
    input  address, din, rden, wren, mq, mready,
    output ready, done, hit_miss, q,
    output mdout, mrden, mwren, maddress
  );

  modport master (
    output address, din, rden, wren, mq, mready,
    input  ready, done, hit_miss, q,
    input  mdout, mrden, mwren, maddress
  );
endinterface

// File: rtl/cache_2way_wb.sv
// cache_2way_wb: 2-way set-assoc write-back write-allocate data cache
// Define CACHE_STATS_EN to add hit/miss/writeback counter ports.
module cache_2way_wb #(
  parameter int MEM_WIDTH      = 32,
  parameter int MEM_DEPTH      = 2**16,
  parameter int NUM_SETS       = 128,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic clk,
  input  logic rst,
  cache_2way_wb_if.slave bus
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
`endif
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int BYTE_W     = $clog2(MEM_WIDTH / 8);
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int WORD_W     = $clog2(WORDS_PER_LINE);
  localparam int TAG_W      = ADDR_WIDTH - INDEX_W - WORD_W;
  localparam logic [WORD_W:0] LAST_W =
    (WORD_W + 1)'(WORDS_PER_LINE - 1);

  typedef enum logic [2:0] {
    IDLE, HIT, EVICT, REFILL, RESP
  } state_t;

  state_t state_q, state_d;

  logic [WORD_W:0]          w_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [MEM_WIDTH-1:0]     din_q;
  logic [MEM_WIDTH-1:0]     q_q;
  logic                     wr_q;
  logic                     way_q;
  logic [1:0][NUM_SETS-1:0] valid_q;
  logic [1:0][NUM_SETS-1:0] dirty_q;
  logic [NUM_SETS-1:0]      lru_q;
  logic [TAG_W-1:0]         tag_q  [2][NUM_SETS];
  logic [MEM_WIDTH-1:0]     data_q [2][NUM_SETS][WORDS_PER_LINE];

  logic [ADDR_WIDTH-1:0] lv_addr;
  logic [INDEX_W-1:0]    lv_idx, r_idx;
  logic [TAG_W-1:0]      lv_tag, r_tag;
  logic [WORD_W-1:0]     r_word, w_cur;
  logic hit0, hit1, vict, req;
  logic beat, last, fin;
  logic unused_lo;

  assign lv_addr   = bus.address[BYTE_W +: ADDR_WIDTH];
  assign unused_lo = ^bus.address;
  assign lv_idx    = lv_addr[WORD_W +: INDEX_W];
  assign lv_tag    = lv_addr[ADDR_WIDTH-1 -: TAG_W];
  assign r_idx     = addr_q[WORD_W +: INDEX_W];
  assign r_tag     = addr_q[ADDR_WIDTH-1 -: TAG_W];
  assign r_word    = addr_q[WORD_W-1:0];
  assign w_cur     = w_q[WORD_W-1:0];

  assign hit0 = valid_q[0][lv_idx] &&
                (tag_q[0][lv_idx] == lv_tag);
  assign hit1 = valid_q[1][lv_idx] &&
                (tag_q[1][lv_idx] == lv_tag);
  assign vict = !valid_q[0][lv_idx] ? 1'b0 :
                !valid_q[1][lv_idx] ? 1'b1 :
                lru_q[lv_idx];
  assign req  = bus.rden | bus.wren;
  assign beat = bus.mready &&
                (state_q == EVICT || state_q == REFILL);
  assign last = beat && (w_q == LAST_W);
  assign fin  = (state_q == HIT) || (state_q == RESP);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and bus outputs
  always_comb begin
    state_d      = state_q;
    bus.ready    = 1'b0;
    bus.done     = 1'b0;
    bus.hit_miss = 1'b0;
    bus.mrden    = 1'b0;
    bus.mwren    = 1'b0;
    bus.maddress = '0;
    bus.mdout    = '0;
    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (req) begin
          if (hit0 || hit1)
            state_d = HIT;
          else if (valid_q[vict][lv_idx] &&
                   dirty_q[vict][lv_idx])
            state_d = EVICT;
          else
            state_d = REFILL;
        end
      end
      HIT: begin
        bus.done     = 1'b1;
        bus.hit_miss = 1'b1;
        state_d      = IDLE;
      end
      EVICT: begin
        bus.mwren    = 1'b1;
        bus.maddress = {tag_q[way_q][r_idx], r_idx, w_cur};
        bus.mdout    = data_q[way_q][r_idx][w_cur];
        if (last) state_d = REFILL;
      end
      REFILL: begin
        bus.mrden    = 1'b1;
        bus.maddress = {r_tag, r_idx, w_cur};
        if (last) state_d = RESP;
      end
      RESP: begin
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    bus.q = (fin && !wr_q) ?
            data_q[way_q][r_idx][r_word] : q_q;
  end

  // request latch, beat counter, valid/dirty/lru, held load data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q     <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      q_q     <= '0;
      wr_q    <= 1'b0;
      way_q   <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q <= lv_addr;
        din_q  <= bus.din;
        wr_q   <= bus.wren;
        way_q  <= hit0 ? 1'b0 : hit1 ? 1'b1 : vict;
      end
      if (beat) w_q <= last ? '0 : w_q + 1'b1;
      if (last && state_q == REFILL) begin
        valid_q[way_q][r_idx] <= 1'b1;
        dirty_q[way_q][r_idx] <= 1'b0;
      end
      if (fin) begin
        lru_q[r_idx] <= ~way_q;
        if (wr_q) dirty_q[way_q][r_idx] <= 1'b1;
        else      q_q <= data_q[way_q][r_idx][r_word];
      end
    end
  end

  // line storage: refill beats, store merge, tag install
  always_ff @(posedge clk) begin
    if (state_q == REFILL && bus.mready)
      data_q[way_q][r_idx][w_cur] <= bus.mq;
    if (fin && wr_q)
      data_q[way_q][r_idx][r_word] <= din_q;
    if (last && state_q == REFILL)
      tag_q[way_q][r_idx] <= r_tag;
  end

`ifdef CACHE_STATS_EN
  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (state_q == HIT && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (state_q == RESP && miss_count != '1)
        miss_count <= miss_count + 1'b1;
      if (last && state_q == EVICT && wb_count != '1)
        wb_count <= wb_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_2way_wb.sv
// tb_cache_2way_wb: random loads/stores vs a per-set recency-list model
// Memory is a flat array; mready is tied, random, or every third cycle.
`timescale 1ns/1ps
module tb_cache_2way_wb;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_2way_wb_if bus ();

`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count, wb_count;
`endif

  cache_2way_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
`endif
  );

  logic [31:0] mem   [65536];
  logic [31:0] truth [65536];
  assign bus.mq = mem[bus.maddress];

  int total = 0;
  int bad   = 0;

  int mode = 0;
  int cyc  = 0;
  int rd_q [$];
  int wr_a [$];
  logic [31:0] wr_d [$];
  int both_err = 0;
  int stab_err = 0;
  bit pend_rd = 0;
  logic [15:0] pend_a;

  int mru [128];
  int old [128];
  bit ldirty [16384];
  int m_hit, m_miss, m_wb;

  function automatic logic [31:0] pat(input int a);
    return {16'(a) ^ 16'hA5C3, 16'(a)};
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 128; s++) begin
      mru[s] = -1;
      old[s] = -1;
    end
    for (int l = 0; l < 16384; l++) ldirty[l] = 0;
    for (int a = 0; a < 65536; a++) truth[a] = mem[a];
    m_hit  = 0;
    m_miss = 0;
    m_wb   = 0;
  endtask

  // memory side: pick mready, record accepted beats, apply writes
  always @(negedge clk) begin
    cyc++;
    if (mode == 0)      bus.mready = 1'b1;
    else if (mode == 1) bus.mready = ($urandom_range(0, 2) == 0);
    else                bus.mready = (cyc % 3 == 0);
    if (bus.mrden && bus.mwren) both_err++;
    if (pend_rd && !(bus.mrden && bus.maddress == pend_a))
      stab_err++;
    pend_rd = bus.mrden && !bus.mready;
    pend_a  = bus.maddress;
    if (bus.mready && bus.mrden)
      rd_q.push_back(int'(bus.maddress));
    if (bus.mready && bus.mwren) begin
      wr_a.push_back(int'(bus.maddress));
      wr_d.push_back(bus.mdout);
      mem[bus.maddress] = bus.mdout;
    end
  end

  task automatic do_req(input logic rd, input logic wr,
                        input logic [17:0] ba,
                        input logic [31:0] d);
    int wa, ln, s, vic, lat;
    bit exp_hit, exp_wb;
    logic [31:0] exp_q;
    wa  = int'(ba[17:2]);
    ln  = wa >> 2;
    s   = ln % 128;
    vic = -1;
    lat = 0;
    @(negedge clk);
    while (!bus.ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ready", bus.ready, 1'b1);
    exp_hit = (mru[s] == ln) || (old[s] == ln);
    if (exp_hit) begin
      if (old[s] == ln) begin
        old[s] = mru[s];
        mru[s] = ln;
      end
      m_hit++;
    end else begin
      if (mru[s] != -1) begin
        if (old[s] != -1) vic = old[s];
        old[s] = mru[s];
      end
      mru[s] = ln;
      ldirty[ln] = 0;
      m_miss++;
    end
    exp_wb = (vic != -1) && ldirty[vic];
    if (exp_wb) m_wb++;
    if (wr) begin
      truth[wa] = d;
      ldirty[ln] = 1;
    end
    exp_q = truth[wa];
    rd_q.delete();
    wr_a.delete();
    wr_d.delete();
    bus.address = ba;
    bus.din     = d;
    bus.rden    = rd;
    bus.wren    = wr;
    @(posedge clk);
    #1;
    bus.rden = 1'b0;
    bus.wren = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.done && lat < 300);
    chk("done", bus.done, 1'b1);
    chk("hit_miss", bus.hit_miss, exp_hit);
    if (!wr) chk("q", bus.q, exp_q);
    if (mode == 0)
      chk("latency", lat,
          exp_hit ? 1 : exp_wb ? 1 + 2 * W : 1 + W);
    chk("n_rd", rd_q.size(), exp_hit ? 0 : W);
    chk("n_wr", wr_a.size(), exp_wb ? W : 0);
    for (int i = 0; i < rd_q.size() && i < W; i++)
      chk("rd_addr", rd_q[i], ln * 4 + i);
    for (int i = 0; i < wr_a.size() && i < W; i++) begin
      chk("wb_addr", wr_a[i], vic * 4 + i);
      chk("wb_data", wr_d[i], truth[vic * 4 + i]);
    end
  endtask

  task automatic reset_mid_refill(input logic [17:0] ba);
    int n;
    mode = 2;
    @(negedge clk);
    rd_q.delete();
    bus.address = ba;
    bus.rden    = 1'b1;
    @(posedge clk);
    #1;
    bus.rden = 1'b0;
    n = 0;
    while (rd_q.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rst_reach_refill", bus.mrden, 1'b1);
    #2;
    rst = 1'b1;
    pend_rd = 0;
    #1;
    chk("rst_mrden", bus.mrden, 1'b0);
    chk("rst_mwren", bus.mwren, 1'b0);
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_q", bus.q, 32'h0);
    model_reset();
    @(negedge clk);
    rst  = 1'b0;
    mode = 0;
  endtask

  initial begin
    bus.address = '0;
    bus.din     = '0;
    bus.rden    = 1'b0;
    bus.wren    = 1'b0;
    bus.mready  = 1'b1;
    for (int a = 0; a < 65536; a++) mem[a] = pat(a);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", bus.ready, 1'b1);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_hm", bus.hit_miss, 1'b0);
    chk("reset_q", bus.q, 32'h0);
    chk("reset_mrden", bus.mrden, 1'b0);
    chk("reset_mwren", bus.mwren, 1'b0);
    chk("reset_maddr", bus.maddress, 16'h0);
    chk("reset_mdout", bus.mdout, 32'h0);
    rst = 1'b0;

    do_req(1'b1, 1'b0, 18'h00040, 32'h0);
    chk("cold_q", bus.q, 32'hA5D3_0010);
    do_req(1'b1, 1'b0, 18'h00044, 32'h0);
    chk("hit_q", bus.q, 32'hA5D2_0011);

    do_req(1'b0, 1'b1, 18'h00040, 32'hAAAA5555);
    do_req(1'b1, 1'b0, 18'h00840, 32'h0);
    do_req(1'b1, 1'b0, 18'h01040, 32'h0);
    chk("wb_word0_addr", wr_a[0], 16'h0010);
    chk("wb_word0_data", wr_d[0], 32'hAAAA5555);

    mode = 2;
    do_req(1'b1, 1'b0, 18'h00208, 32'h0);
    mode = 0;

    reset_mid_refill(18'h20040);
    do_req(1'b1, 1'b0, 18'h20040, 32'h0);

    do_req(1'b1, 1'b1, 18'h20044, 32'h12345678);
    do_req(1'b1, 1'b0, 18'h20044, 32'h0);
    chk("both_is_store", bus.q, 32'h12345678);
`ifdef CACHE_STATS_EN
    chk("hits_dir", hit_count, m_hit);
    chk("miss_dir", miss_count, m_miss);
    chk("wb_dir", wb_count, m_wb);
`endif

    for (int k = 0; k < 400; k++) begin
      logic [17:0] ba;
      logic [31:0] d;
      int t;
      mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
      ba = 18'(($urandom_range(0, 2) << 11) |
               ($urandom_range(0, 3) << 4) |
               ($urandom_range(0, 3) << 2) |
               $urandom_range(0, 3));
      d = $urandom;
      t = $urandom_range(0, 3);
      if (t < 2)       do_req(1'b1, 1'b0, ba, d);
      else if (t == 2) do_req(1'b0, 1'b1, ba, d);
      else             do_req(1'b1, 1'b1, ba, d);
    end
    mode = 0;

    chk("both_strobes", both_err, 0);
    chk("hold_stable", stab_err, 0);
`ifdef CACHE_STATS_EN
    chk("hits_end", hit_count, m_hit);
    chk("miss_end", miss_count, m_miss);
    chk("wb_end", wb_count, m_wb);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
